sar_ctrl_adc: RTL and testbench

SAR_CTRL_ADC -- requirements
Module: sar_ctrl_adc

---
 rtl/sar_ctrl_adc.sv | 94 +++++++++
 tb/tb_sar_ctrl_adc.sv | 118 +++++++++++
 2 files changed

// File: rtl/sar_ctrl_adc.sv
// sar_ctrl_adc: successive-approximation ADC controller with trimmable sample phase.
module sar_ctrl_adc #(
  parameter int NBITS = 11
) (
  input  logic             clk_adc,
  input  logic             rstn_adc,
  input  logic             start,
  input  logic [2:0]       trm,
  input  logic             cmp_out,
  output logic             sample,
  output logic [NBITS-1:0] dac_code,
  output logic [NBITS-1:0] out_bits,
  output logic             valid,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;
  localparam int IW = $clog2(NBITS);
  localparam logic [IW-1:0] TOP = IW'(NBITS - 1);
  localparam logic [NBITS-1:0] ONE = {{(NBITS-1){1'b0}}, 1'b1};
  localparam logic [NBITS-1:0] MSB = ONE << (NBITS - 1);
  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [2:0]       cnt_q, cnt_d, trm_q, trm_d;
  logic [NBITS-1:0] dac_q, dac_d, out_q, out_d, bit_m, kept;
  logic             sample_q, sample_d, valid_q, valid_d, busy_q, busy_d;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    trm_d   = trm_q;
    dac_d   = dac_q;
    out_d   = out_q;
    valid_d = 1'b0;
    bit_m   = ONE << idx_q;
    kept    = cmp_out ? dac_q : dac_q & ~bit_m;
    case (state_q)
      IDLE, DONE: begin
        state_d = start ? SAMPLE : IDLE;
        if (start) begin
          trm_d = trm;
          idx_d = TOP;
          cnt_d = 3'd0;
        end
      end
      SAMPLE: begin
        state_d = (cnt_q == trm_q) ? CONVERT : SAMPLE;
        dac_d   = (cnt_q == trm_q) ? MSB : '0;
        cnt_d   = cnt_q + 3'd1;
      end
      default: begin
        // dac_q holds resolved upper bits plus the trial bit; drop it on a low decision
        if (idx_q == '0) begin
          state_d = DONE;
          out_d   = kept;
          dac_d   = '0;
          valid_d = 1'b1;
        end else begin
          dac_d = kept | (bit_m >> 1);
          idx_d = idx_q - 1'b1;
        end
      end
    endcase
    sample_d = state_d == SAMPLE;
    busy_d   = state_d != IDLE;
  end
  always_ff @(posedge clk_adc or negedge rstn_adc) begin
    if (!rstn_adc) begin
      state_q  <= IDLE;
      idx_q    <= TOP;
      cnt_q    <= 3'd0;
      trm_q    <= 3'd0;
      dac_q    <= '0;
      out_q    <= '0;
      sample_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      trm_q    <= trm_d;
      dac_q    <= dac_d;
      out_q    <= out_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end
  assign sample   = sample_q;
  assign dac_code = dac_q;
  assign out_bits = out_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_sar_ctrl_adc.sv
// tb_sar_ctrl_adc: table-driven conversions plus back-to-back, ignored-input and mid-conversion reset sequences.
module tb_sar_ctrl_adc;
  localparam int NB = 11;
  localparam logic [NB-1:0] ONE = 1;
  logic clk = 1'b0, rstn = 1'b1, start = 1'b0, cmp_out = 1'b0;
  logic [2:0] trm = 3'd0;
  logic sample, valid, busy;
  logic [NB-1:0] dac_code, out_bits;
  logic [NB-1:0] prev_out = '0;
  int nvec = 0, nerr = 0;
  typedef struct {
    logic [2:0]    tr;
    logic [NB-1:0] tgt;
    logic [NB-1:0] eo;
    int            evc;
  } vec_t;
  vec_t tbl[6];
  always #5 clk = ~clk;
  sar_ctrl_adc #(.NBITS(NB)) dut (
    .clk_adc(clk), .rstn_adc(rstn), .start(start), .trm(trm), .cmp_out(cmp_out),
    .sample(sample), .dac_code(dac_code), .out_bits(out_bits), .valid(valid), .busy(busy)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic run(input logic [2:0] tr, input logic [NB-1:0] tgt, input logic [NB-1:0] eo,
                     input int evc, input bit keep, input bit noise);
    logic [NB-1:0] res, edac;
    bit conv;
    int t;
    t = int'(tr);
    res = '0;
    trm = tr;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= evc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = keep;
        if (noise) trm = 3'd7;
      end
      if (noise && c == t + 6) start = 1'b1;
      if (noise && c == t + 7) start = keep;
      conv = c >= t + 2 && c <= t + NB + 1;
      edac = conv ? (res | (ONE << (NB - 1 - (c - t - 2)))) : '0;
      cmp_out = tgt >= edac;
      chk("sample", 32'(sample), 32'(c <= t + 1));
      chk("dac_code", 32'(dac_code), 32'(edac));
      chk("valid", 32'(valid), 32'(c == evc));
      chk("busy", 32'(busy), 32'd1);
      chk("out_bits", 32'(out_bits), 32'(c == evc ? eo : prev_out));
      if (conv && cmp_out) res = edac;
    end
    prev_out = eo;
    if (!keep) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_sample", 32'(sample), 32'd0);
      chk("idle_dac", 32'(dac_code), 32'd0);
      chk("hold_out", 32'(out_bits), 32'(eo));
    end
    trm = 3'd0;
  endtask
  initial begin
    tbl[0] = '{3'd0, 11'h7FF, 11'h7FF, 13};
    tbl[1] = '{3'd7, 11'h000, 11'h000, 20};
    tbl[2] = '{3'd3, 11'h2A5, 11'h2A5, 16};
    tbl[3] = '{3'd5, 11'h400, 11'h400, 18};
    tbl[4] = '{3'd1, 11'h3FF, 11'h3FF, 14};
    tbl[5] = '{3'd2, 11'h001, 11'h001, 15};
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_dac", 32'(dac_code), 32'd0);
    chk("rst_out", 32'(out_bits), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) run(tbl[i].tr, tbl[i].tgt, tbl[i].eo, tbl[i].evc, 1'b0, 1'b0);
    run(3'd0, 11'h155, 11'h155, 13, 1'b1, 1'b0);
    run(3'd0, 11'h6AA, 11'h6AA, 13, 1'b1, 1'b0);
    run(3'd0, 11'h0F0, 11'h0F0, 13, 1'b0, 1'b0);
    run(3'd0, 11'h333, 11'h333, 13, 1'b0, 1'b1);
    trm = 3'd2;
    start = 1'b1;
    cmp_out = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_dac", 32'(dac_code), 32'h7C0);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_sample", 32'(sample), 32'd0);
    chk("arst_dac", 32'(dac_code), 32'd0);
    chk("arst_out", 32'(out_bits), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    prev_out = '0;
    @(negedge clk);
    chk("arst_idle_busy", 32'(busy), 32'd0);
    chk("arst_idle_valid", 32'(valid), 32'd0);
    chk("arst_idle_out", 32'(out_bits), 32'd0);
    run(tbl[2].tr, tbl[2].tgt, tbl[2].eo, tbl[2].evc, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
